// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush squash.
// Latency: ex_* outputs follow id_* by one clock; stall is combinational in the same cycle.
// Backpressure: stall asserts for one cycle per load-use hazard so PC and IF/ID hold; flush overrides it.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    id_alu_op,
    input  logic          id_reg_dst,
    input  logic          id_branch,
    input  logic          id_mem_read,
    input  logic          id_mem_to_reg,
    input  logic          id_mem_write,
    input  logic          id_alu_src,
    input  logic          id_reg_write,
    input  logic          id_jump,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [5:0]    id_funct,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic          flush,
    output logic [1:0]    ex_alu_op,
    output logic          ex_reg_dst,
    output logic          ex_branch,
    output logic          ex_mem_read,
    output logic          ex_mem_to_reg,
    output logic          ex_mem_write,
    output logic          ex_alu_src,
    output logic          ex_reg_write,
    output logic          ex_jump,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [5:0]    ex_funct,
    output logic [DW-1:0] ex_rdata1,
    output logic [DW-1:0] ex_rdata2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic          stall,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    // Control half of the EX register
    logic [1:0]    r_alu_op;
    logic          r_reg_dst;
    logic          r_branch;
    logic          r_mem_read;
    logic          r_mem_to_reg;
    logic          r_mem_write;
    logic          r_alu_src;
    logic          r_reg_write;
    logic          r_jump;

    // Data half of the EX register; meaningless when the control half is a bubble
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic [4:0]    r_rd;
    logic [5:0]    r_funct;
    logic [DW-1:0] r_rdata1;
    logic [DW-1:0] r_rdata2;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_pc4;

    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] r_flush_cnt;

    logic          w_rt_used;
    logic          w_hz;
    logic          w_bubble;

    // Load-use detection against the load currently in EX; lw/addi-style decodes do not read rt,
    // stores do, and jumps read no registers at all. Register 0 never carries a dependency.
    always_comb begin
        w_rt_used = ~id_alu_src | id_mem_write;
        w_hz      = r_mem_read && (r_rt != 5'd0) && !id_jump &&
                    ((r_rt == id_rs) || ((r_rt == id_rt) && w_rt_used));
        w_bubble  = flush | w_hz;
        stall     = w_hz & ~flush;
    end

    // Control fields: reset clears, flush or hazard inserts a bubble, otherwise follow decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_op     <= 2'b00;
            r_reg_dst    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_jump       <= 1'b0;
        end else if (w_bubble) begin
            r_alu_op     <= 2'b00;
            r_reg_dst    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_jump       <= 1'b0;
        end else begin
            r_alu_op     <= id_alu_op;
            r_reg_dst    <= id_reg_dst;
            r_branch     <= id_branch;
            r_mem_read   <= id_mem_read;
            r_mem_to_reg <= id_mem_to_reg;
            r_mem_write  <= id_mem_write;
            r_alu_src    <= id_alu_src;
            r_reg_write  <= id_reg_write;
            r_jump       <= id_jump;
        end
    end

    // Data fields always follow decode outside reset; a bubble makes them don't-care
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs     <= 5'd0;
            r_rt     <= 5'd0;
            r_rd     <= 5'd0;
            r_funct  <= 6'd0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_pc4    <= '0;
        end else begin
            r_rs     <= id_rs;
            r_rt     <= id_rt;
            r_rd     <= id_rd;
            r_funct  <= id_funct;
            r_rdata1 <= id_rdata1;
            r_rdata2 <= id_rdata2;
            r_imm    <= id_imm;
            r_pc4    <= id_pc4;
        end
    end

    // Saturating event counters; flush takes precedence so a flushed hazard counts only as a flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign ex_alu_op     = r_alu_op;
    assign ex_reg_dst    = r_reg_dst;
    assign ex_branch     = r_branch;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_mem_write  = r_mem_write;
    assign ex_alu_src    = r_alu_src;
    assign ex_reg_write  = r_reg_write;
    assign ex_jump       = r_jump;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rd         = r_rd;
    assign ex_funct      = r_funct;
    assign ex_rdata1     = r_rdata1;
    assign ex_rdata2     = r_rdata2;
    assign ex_imm        = r_imm;
    assign ex_pc4        = r_pc4;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

endmodule
